// File: rtl/block_scrambler_if.sv
// -----------------------------------------------------------------------------
// block_scrambler_if
// Purpose : bundles the sample streams, handshakes, key/mode configuration and
//           status of the block scrambler so they travel as one port.
// Signals :
//   key        permutation key, field j = key[(N-1-j)*LOG2N +: LOG2N]
//   mode       0 = scramble, 1 = descramble
//   in_real/in_imag, in_valid, in_ready       input sample stream
//   out_real/out_imag, out_valid, out_ready   output sample stream
//   out_first  marks sample 0 of every output block
//   key_error  set for a whole output block whose key is not a permutation
// Modports:
//   slave  - the scrambler itself (consumes input stream, produces output)
//   master - the environment driving the scrambler
// -----------------------------------------------------------------------------
interface block_scrambler_if #(
   parameter int DATA_W = 16,
   parameter int LOG2N  = 3
);
   localparam int N     = 1 << LOG2N;
   localparam int KEY_W = N * LOG2N;

   logic [KEY_W-1:0]         key;
   logic                     mode;
   logic signed [DATA_W-1:0] in_real;
   logic signed [DATA_W-1:0] in_imag;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] out_real;
   logic signed [DATA_W-1:0] out_imag;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_first;
   logic                     key_error;

   modport slave (
      input  key, mode, in_real, in_imag, in_valid, out_ready,
      output in_ready, out_real, out_imag, out_valid, out_first, key_error
   );

   modport master (
      output key, mode, in_real, in_imag, in_valid, out_ready,
      input  in_ready, out_real, out_imag, out_valid, out_first, key_error
   );
endinterface

// File: rtl/block_scrambler.sv
// -----------------------------------------------------------------------------
// block_scrambler
// Purpose : permutes blocks of N = 2^LOG2N complex samples according to a
//           per-block key. Two N-sample banks work ping-pong: one fills in
//           arrival order while the other drains in permuted order.
//           Scramble   : output position j <- slot field[j]
//           Descramble : output position field[j] <- slot j (inverse)
//           An all-zero key passes the block through in arrival order.
// Ports   :
//   clock  single clock, rising edge
//   reset  asynchronous, active-low
//   bus    block_scrambler_if.slave (streams, key/mode, out_first, key_error)
// Config  : define BLOCK_SCRAMBLER_KEYCHECK_EN to build the key checker; a key
//           with duplicate fields then raises key_error for that block and the
//           block is passed through in arrival order. Without it key_error is
//           tied low and duplicate keys are applied as given.
// -----------------------------------------------------------------------------
module block_scrambler #(
   parameter int DATA_W = 16,
   parameter int LOG2N  = 3
) (
   input  logic           clock,
   input  logic           reset,
   block_scrambler_if.slave bus
);
   localparam int N     = 1 << LOG2N;
   localparam int KEY_W = N * LOG2N;

   typedef logic [LOG2N-1:0] idx_t;

   // field j of a key; field 0 sits in the MSBs
   function automatic idx_t field_of(input logic [KEY_W-1:0] k, input idx_t j);
      return k[(N - 1 - int'(j)) * LOG2N +: LOG2N];
   endfunction

`ifdef BLOCK_SCRAMBLER_KEYCHECK_EN
   function automatic logic has_dup(input logic [KEY_W-1:0] k);
      logic dup;
      dup = 1'b0;
      for (int i = 0; i < N - 1; i++) begin
         for (int j = i + 1; j < N; j++) begin
            if (field_of(k, idx_t'(i)) == field_of(k, idx_t'(j))) dup = 1'b1;
         end
      end
      return dup;
   endfunction
`endif

   // sample storage (data only, never reset)
   logic signed [DATA_W-1:0] mem_real [2][N];
   logic signed [DATA_W-1:0] mem_imag [2][N];

   // control state
   logic             run;          // low until the first edge after reset release
   logic [1:0]       full;
   idx_t             wr_idx;
   idx_t             rd_idx;
   logic             fill_bank;
   logic             drain_bank;
   logic [KEY_W-1:0] bank_key [2];
   logic [1:0]       bank_mode;
   logic [1:0]       bank_byp;
`ifdef BLOCK_SCRAMBLER_KEYCHECK_EN
   logic [1:0]       bank_err;
`endif

   logic             in_fire;
   logic             out_fire;
   logic             key_byp;
   logic [KEY_W-1:0] cur_key;
   idx_t             rd_addr;

   // A bank being filled is never full, so one flag covers both stall causes:
   // both banks full, or the next fill bank has not finished draining.
   assign bus.in_ready = run & ~full[fill_bank];
   assign in_fire      = bus.in_valid & bus.in_ready;
   assign out_fire     = full[drain_bank] & bus.out_ready;

`ifdef BLOCK_SCRAMBLER_KEYCHECK_EN
   assign key_byp = (bus.key == '0) | has_dup(bus.key);
`else
   assign key_byp = (bus.key == '0);
`endif

   // ---- fill side: control state and bank/key latching ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         run         <= 1'b0;
         full        <= '0;
         wr_idx      <= '0;
         rd_idx      <= '0;
         fill_bank   <= 1'b0;
         drain_bank  <= 1'b0;
         bank_key[0] <= '0;
         bank_key[1] <= '0;
         bank_mode   <= '0;
         bank_byp    <= '0;
`ifdef BLOCK_SCRAMBLER_KEYCHECK_EN
         bank_err    <= '0;
`endif
      end else begin
         run <= 1'b1;

         if (in_fire) begin
            // key/mode belong to the block whose sample 0 is being accepted
            if (wr_idx == '0) begin
               bank_key[fill_bank]  <= bus.key;
               bank_mode[fill_bank] <= bus.mode;
               bank_byp[fill_bank]  <= key_byp;
`ifdef BLOCK_SCRAMBLER_KEYCHECK_EN
               bank_err[fill_bank]  <= has_dup(bus.key);
`endif
            end
            if (wr_idx == idx_t'(N - 1)) begin
               wr_idx          <= '0;
               fill_bank       <= ~fill_bank;
               full[fill_bank] <= 1'b1;
            end else begin
               wr_idx <= wr_idx + 1'b1;
            end
         end

         // fill and drain banks differ whenever both fire, so the two full
         // updates never touch the same bit
         if (out_fire) begin
            if (rd_idx == idx_t'(N - 1)) begin
               rd_idx           <= '0;
               drain_bank       <= ~drain_bank;
               full[drain_bank] <= 1'b0;
            end else begin
               rd_idx <= rd_idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (in_fire) begin
         mem_real[fill_bank][wr_idx] <= bus.in_real;
         mem_imag[fill_bank][wr_idx] <= bus.in_imag;
      end
   end

   // ---- drain side: permuted read address and outputs ----
   always_comb begin
      cur_key = bank_key[drain_bank];
      rd_addr = rd_idx;
      if (!bank_byp[drain_bank]) begin
         if (!bank_mode[drain_bank]) begin
            rd_addr = field_of(cur_key, rd_idx);
         end else begin
            // inverse lookup: slot j whose field equals this output position;
            // lowest j wins if the key repeats a field
            for (int j = N - 1; j >= 0; j--) begin
               if (field_of(cur_key, idx_t'(j)) == rd_idx) rd_addr = idx_t'(j);
            end
         end
      end
   end

   // outputs come straight from the full drain bank, so they hold while stalled
   assign bus.out_valid = full[drain_bank];
   assign bus.out_real  = full[drain_bank] ? mem_real[drain_bank][rd_addr] : '0;
   assign bus.out_imag  = full[drain_bank] ? mem_imag[drain_bank][rd_addr] : '0;
   assign bus.out_first = full[drain_bank] & (rd_idx == '0);
`ifdef BLOCK_SCRAMBLER_KEYCHECK_EN
   assign bus.key_error = full[drain_bank] & bank_err[drain_bank];
`else
   assign bus.key_error = 1'b0;
`endif

endmodule

// File: tb/tb_block_scrambler.sv
// -----------------------------------------------------------------------------
// tb_block_scrambler
// Purpose : directed self-checking bench for block_scrambler with N = 8.
//           Inputs change 1 time unit after the rising edge; handshakes and
//           outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_block_scrambler;
   localparam int DATA_W = 16;
   localparam int LOG2N  = 3;
   localparam int N      = 8;

   localparam logic [23:0] KEY_REV  = 24'hFAC688; // fields 7,6,5,4,3,2,1,0
   localparam logic [23:0] KEY_MIX  = 24'h631EAC; // fields 3,0,6,1,7,2,5,4
   localparam logic [23:0] KEY_DUP2 = 24'h492492; // all fields 2

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   block_scrambler_if #(.DATA_W(DATA_W), .LOG2N(LOG2N)) bif ();

   block_scrambler #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bif)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] stim_real [$];
   logic [15:0] stim_imag [$];
   logic [15:0] cap_real  [$];
   logic [15:0] cap_imag  [$];
   logic        cap_first [$];
   logic        cap_err   [$];
   int          cap_cyc   [$];
   int          acc_cyc   [$];
   int          sent = 0;
   int          cyc  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic drive();
      if (sent < stim_real.size()) begin
         bif.in_valid = 1'b1;
         bif.in_real  = stim_real[sent];
         bif.in_imag  = stim_imag[sent];
      end else begin
         bif.in_valid = 1'b0;
      end
   endtask

   task automatic clear();
      stim_real.delete(); stim_imag.delete();
      cap_real.delete();  cap_imag.delete();
      cap_first.delete(); cap_err.delete();
      cap_cyc.delete();   acc_cyc.delete();
      sent = 0;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (bif.in_valid && bif.in_ready) begin
         acc_cyc.push_back(cyc);
         sent++;
      end
      if (bif.out_valid && bif.out_ready) begin
         cap_real.push_back(bif.out_real);
         cap_imag.push_back(bif.out_imag);
         cap_first.push_back(bif.out_first);
         cap_err.push_back(bif.key_error);
         cap_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_until(input int n, input int budget, input string tag);
      int b;
      b = budget;
      while (cap_real.size() < n && b > 0) begin
         step();
         b--;
      end
      check({tag, "_count"}, cap_real.size(), n);
   endtask

   task automatic wait_sent(input int n, input int budget, input string tag);
      int b;
      b = budget;
      while (sent < n && b > 0) begin
         step();
         b--;
      end
      check({tag, "_sent"}, sent, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] orig_real [$];
      logic [15:0] orig_imag [$];
      logic [15:0] scr_real  [$];
      logic [15:0] scr_imag  [$];
      int          fmix [8];

      fmix = '{3, 0, 6, 1, 7, 2, 5, 4};

      bif.key       = '0;
      bif.mode      = 1'b0;
      bif.in_real   = '0;
      bif.in_imag   = '0;
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b1;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  bif.in_ready,  0);
      check("rst_out_valid", bif.out_valid, 0);
      check("rst_out_first", bif.out_first, 0);
      check("rst_key_error", bif.key_error, 0);
      check("rst_out_real",  16'(bif.out_real), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready_before_edge", bif.in_ready, 0);
      @(posedge clk);
      #1;
      check("rel_in_ready_after_edge", bif.in_ready, 1);

      // ---- reversal key, late key/mode change ignored ----
      clear();
      for (int i = 0; i < N; i++) begin
         stim_real.push_back(16'(i + 1));
         stim_imag.push_back(16'(101 + i));
      end
      bif.key  = KEY_REV;
      bif.mode = 1'b0;
      drive();
      wait_sent(1, 20, "rev");
      bif.key  = '0;
      bif.mode = 1'b1;
      run_until(N, 100, "rev");
      for (int j = 0; j < N && j < cap_real.size(); j++) begin
         check($sformatf("rev_data[%0d]", j), {cap_real[j], cap_imag[j]},
               {16'(8 - j), 16'(108 - j)});
         check($sformatf("rev_first[%0d]", j), cap_first[j], (j == 0));
      end

      // ---- scramble then descramble 64 random samples ----
      clear();
      for (int i = 0; i < 64; i++) begin
         orig_real.push_back(16'($urandom));
         orig_imag.push_back(16'($urandom));
      end
      stim_real = orig_real;
      stim_imag = orig_imag;
      bif.key   = KEY_MIX;
      bif.mode  = 1'b0;
      drive();
      run_until(64, 400, "scr");
      for (int j = 0; j < N && j < cap_real.size(); j++)
         check($sformatf("scr_pos[%0d]", j), cap_real[j], orig_real[fmix[j]]);
      scr_real = cap_real;
      scr_imag = cap_imag;
      clear();
      stim_real = scr_real;
      stim_imag = scr_imag;
      bif.mode  = 1'b1;
      drive();
      run_until(64, 400, "dscr");
      for (int k = 0; k < 64 && k < cap_real.size(); k++)
         check($sformatf("dscr[%0d]", k), {cap_real[k], cap_imag[k]},
               {orig_real[k], orig_imag[k]});

      // ---- zero key bypass, latency and throughput ----
      clear();
      for (int i = 0; i < 2 * N; i++) begin
         stim_real.push_back(16'(200 + i));
         stim_imag.push_back(16'(300 + i));
      end
      bif.key  = '0;
      bif.mode = 1'b1;
      drive();
      run_until(2 * N, 100, "byp");
      if (cap_real.size() == 2 * N && acc_cyc.size() == 2 * N) begin
         for (int k = 0; k < 2 * N; k++)
            check($sformatf("byp[%0d]", k), cap_real[k], 16'(200 + k));
         check("byp_latency",   cap_cyc[0] - acc_cyc[N - 1], 1);
         check("byp_out_rate",  cap_cyc[2 * N - 1] - cap_cyc[0], 2 * N - 1);
         check("byp_in_rate",   acc_cyc[2 * N - 1] - acc_cyc[0], 2 * N - 1);
      end

      // ---- output stall: backpressure and hold ----
      clear();
      for (int i = 0; i < 3 * N; i++) begin
         stim_real.push_back(16'(i + 1));
         stim_imag.push_back(16'(500 + i));
      end
      bif.key       = KEY_REV;
      bif.mode      = 1'b0;
      bif.out_ready = 1'b0;
      drive();
      repeat (20) step();
      check("stall_sent",      sent, 2 * N);
      check("stall_in_ready",  bif.in_ready, 0);
      check("stall_out_valid", bif.out_valid, 1);
      check("stall_out_real",  16'(bif.out_real), 8);
      check("stall_out_first", bif.out_first, 1);
      bif.out_ready = 1'b1;
      run_until(3 * N, 200, "stall");
      for (int k = 0; k < 3 * N && k < cap_real.size(); k++)
         check($sformatf("stall_data[%0d]", k), cap_real[k], 16'((k / 8) * 8 + 8 - (k % 8)));

      // ---- reset mid-block ----
      clear();
      for (int i = 0; i < N; i++) begin
         stim_real.push_back(16'(50 + i));
         stim_imag.push_back(16'(0));
      end
      bif.key  = '0;
      bif.mode = 1'b0;
      drive();
      wait_sent(5, 20, "mid");
      rst_n        = 1'b0;
      bif.in_valid = 1'b0;
      #1;
      check("mid_rst_out_valid", bif.out_valid, 0);
      check("mid_rst_in_ready",  bif.in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      clear();
      for (int i = 0; i < N; i++) begin
         stim_real.push_back(16'(60 + i));
         stim_imag.push_back(16'(0));
      end
      drive();
      run_until(N, 100, "post");
      for (int k = 0; k < N && k < cap_real.size(); k++)
         check($sformatf("post[%0d]", k), cap_real[k], 16'(60 + k));
      repeat (10) step();
      check("post_no_extra", cap_real.size(), N);

      // ---- duplicate key ----
      clear();
      for (int i = 0; i < N; i++) begin
         stim_real.push_back(16'(70 + i));
         stim_imag.push_back(16'(0));
      end
      bif.key  = KEY_DUP2;
      bif.mode = 1'b0;
      drive();
      run_until(N, 100, "dup");
      for (int k = 0; k < N && k < cap_real.size(); k++) begin
`ifdef BLOCK_SCRAMBLER_KEYCHECK_EN
         check($sformatf("dup_data[%0d]", k), cap_real[k], 16'(70 + k));
         check($sformatf("dup_err[%0d]", k),  cap_err[k], 1);
`else
         check($sformatf("dup_data[%0d]", k), cap_real[k], 16'(72));
         check($sformatf("dup_err[%0d]", k),  cap_err[k], 0);
`endif
      end
      repeat (2) step();
      check("dup_err_after", bif.key_error, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/block_scrambler.md
BLOCK_SCRAMBLER -- requirements
Module: block_scrambler

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bit width of each of the real and imaginary sample parts.
REQ-002 SHALL have parameter LOG2N, default 3, meaning block size N = 2^LOG2N complex samples; legal range 1..5.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port key, input, N*LOG2N, permutation key; field j is key[(N-1-j)*LOG2N +: LOG2N], field 0 in the MSBs.
REQ-006 SHALL have port mode, input, 1; 0 = scramble, 1 = descramble (inverse permutation).
REQ-007 SHALL have ports in_real and in_imag, input, DATA_W each, input sample.
REQ-008 SHALL have port in_valid, input, 1, and in_ready, output, 1, the input handshake.
REQ-009 SHALL have ports out_real and out_imag, output, DATA_W each, output sample.
REQ-010 SHALL have port out_valid, output, 1, and out_ready, input, 1, the output handshake.
REQ-011 SHALL have port out_first, output, 1, high with sample 0 of each output block.
REQ-012 SHALL have port key_error, output, 1, high for the block whose latched key is not a permutation.

Function
REQ-013 SHALL accept a sample only on in_valid & in_ready, and emit one only on out_valid & out_ready.
REQ-014 SHALL hold two N-sample banks (ping-pong): one fills while the other drains.
REQ-015 SHALL latch key and mode into the filling bank on acceptance of that bank's sample 0; later changes do not affect that block.
REQ-016 SHALL write input samples to bank slot 0..N-1 in arrival order; write index wraps N-1 -> 0 and toggles the fill bank.
REQ-017 SHALL in scramble mode output, at position j, the sample from slot field j.
REQ-018 SHALL in descramble mode output, at position field j, the sample from slot j, so descramble(scramble(x,K),K) = x.
REQ-019 SHALL bypass (output in arrival order) when the latched key is all zeros, regardless of mode.
REQ-020 SHALL mark a bank full when its slot N-1 is written; the drain side starts on the next cycle, giving a minimum latency of 1 cycle from last-sample acceptance to out_valid.
REQ-021 SHALL deassert in_ready only when both banks are full, or the fill bank is still draining.
REQ-022 SHALL, on simultaneous last-sample write into one bank and last-sample read from the other, accept both in that cycle with no bubble.
REQ-023 SHALL hold out_real/out_imag/out_first stable while out_valid & !out_ready.
REQ-024 SHALL sustain 1 sample/cycle throughput when in_valid and out_ready are held high.
REQ-025 SHALL never emit a partial block; an incomplete fill bank is held until completed.

Reset
REQ-026 SHALL, while reset is low, clear both banks' full flags, write/read indices, fill/drain bank pointers, out_valid, out_first, key_error, out_real and out_imag to 0, and drive in_ready to 0.
REQ-027 SHALL, on reset mid-block, discard all buffered samples; in_ready rises on the first clock edge after reset release.

Configuration
REQ-028 SHALL compile the key-permutation checker only when macro BLOCK_SCRAMBLER_KEYCHECK_EN is defined.
REQ-029 SHALL with BLOCK_SCRAMBLER_KEYCHECK_EN: on a duplicate field in the latched key, set key_error for the whole output block and output that block in bypass order.
REQ-030 SHALL without BLOCK_SCRAMBLER_KEYCHECK_EN: tie key_error to 0 and apply duplicate keys as given (samples may be repeated or dropped).

Verification
REQ-031 SHALL cover N=8, key = fields 7,6,5,4,3,2,1,0, mode 0, inputs real 1..8 -> out_real 8,7,...,1, out_first on the first sample only.
REQ-032 SHALL cover N=8, key fields 3,0,6,1,7,2,5,4: scramble then descramble a chain of 64 random samples -> output equals input bit-exactly.
REQ-033 SHALL cover key = 0, mode 1, continuous valid/ready -> in-order output, first out_valid 1 cycle after sample 8 is accepted, then 1 sample/cycle.
REQ-034 SHALL cover out_ready held low for 20 cycles -> in_ready falls after 16 samples are accepted; no data is lost or reordered when out_ready is released.
REQ-035 SHALL cover reset asserted after 5 of 8 samples -> out_valid 0, and the next full block outputs only post-reset samples.
REQ-036 SHALL cover, with BLOCK_SCRAMBLER_KEYCHECK_EN, key fields all 2 -> key_error 1 for 8 outputs and in-order output; without the macro, key_error 0 and 8 copies of slot 2.
